// File: rtl/daq_pkg.sv
// Shared types and helpers for the DAQ packetizer.
// PKT_CHECKSUM_EN (optional macro) adds a trailing checksum word to every packet.
package daq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_SEQ,
      ST_CH,
      ST_CSUM
   } state_e;

   localparam logic [15:0] HEADER_DEFAULT = 16'hA55A;

   function automatic int pkt_bytes(input int num_ch);
`ifdef PKT_CHECKSUM_EN
      return 2 * (num_ch + 3);
`else
      return 2 * (num_ch + 2);
`endif
   endfunction

endpackage

// File: rtl/daq_packetizer_if.sv
// Word strobe and host FIFO read port of the DAQ packetizer.
interface daq_packetizer_if;
   logic [15:0] db_o;
   logic        rdreq_o;
   logic        wrclk_o;
   logic        fifo_out_req;
   logic        fifo_out_empty;
   logic [7:0]  fifo_out_data;

   modport master (
      output db_o, rdreq_o, wrclk_o, fifo_out_empty, fifo_out_data,
      input  fifo_out_req
   );

   modport slave (
      input  db_o, rdreq_o, wrclk_o, fifo_out_empty, fifo_out_data,
      output fifo_out_req
   );
endinterface

// File: rtl/daq_byte_fifo.sv
// Single-clock byte FIFO with registered read data; DEPTH must be a power of 2.
module daq_byte_fifo #(
   parameter int DEPTH = 64,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk_i,
   input  logic          reset_i,
   input  logic          wr_en_i,
   input  logic [7:0]    wr_data_i,
   input  logic          rd_en_i,
   output logic [7:0]    rd_data_o,
   output logic [CW-1:0] count_o,
   output logic          empty_o,
   output logic          full_o
);
   localparam int AW = $clog2(DEPTH);

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [7:0]    data_q, data_d;
   logic          empty_q, empty_d;
   logic          push, pop;

   always_comb begin
      pop      = rd_en_i && !empty_q;
      push     = wr_en_i;
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      data_d   = pop ? mem_q[rd_ptr_q] : data_q;
      count_d  = count_q;
      if (push && !pop)
         count_d = count_q + 1'b1;
      else if (pop && !push)
         count_d = count_q - 1'b1;
      empty_d  = (count_d == '0);
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         data_q   <= '0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         data_q   <= data_d;
         empty_q  <= empty_d;
      end
   end

   // Storage carries no reset; only pointers/count decide what is valid.
   always_ff @(posedge clk_i) begin
      if (push)
         mem_q[wr_ptr_q] <= wr_data_i;
   end

   assign rd_data_o = data_q;
   assign count_o   = count_q;
   assign empty_o   = empty_q;
   assign full_o    = (count_q == CW'(DEPTH));
endmodule

// File: rtl/daq_packetizer.sv
// DAQ framer: period timer, packet FSM and output byte FIFO.
// Define PKT_CHECKSUM_EN to append a wrap-around sum word to each packet.
module daq_packetizer
   import daq_pkg::*;
#(
   parameter int          BASE_PERIOD = 200,
   parameter int          NUM_CH      = 8,
   parameter logic [15:0] HEADER      = HEADER_DEFAULT,
   parameter int          FIFO_DEPTH  = 64
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic [2:0]       os_sel_i,
   input  logic             en_i,
   daq_packetizer_if.master bus
);
   localparam int         TW        = 24;
   localparam int         CW        = $clog2(FIFO_DEPTH) + 1;
   localparam int         PKT_BYTES = pkt_bytes(NUM_CH);
   localparam logic [7:0] LAST_CH   = 8'(NUM_CH - 1);

   logic [TW-1:0] timer_q, timer_d, period_q, period_d, period_sel, period_eff;
   logic          run, tick;
   state_e        state_q, state_d;
   logic          phase_q, phase_d;
   logic [7:0]    ch_q, ch_d;
   logic [15:0]   seq_q, seq_d, frame_seq_q, frame_seq_d, word;
   logic [CW-1:0] fifo_count;
   logic          fifo_full, space_ok, wr_en;
`ifdef PKT_CHECKSUM_EN
   logic [15:0]   csum_q, csum_d;
`endif

   // A period is picked up fresh whenever the timer sits at zero, i.e. after each tick.
   always_comb begin
      run        = en_i && (os_sel_i != 3'd7);
      period_sel = TW'(BASE_PERIOD) << os_sel_i;
      period_eff = (timer_q == '0) ? period_sel : period_q;
      tick       = run && (timer_q == period_eff - 1'b1);
      period_d   = period_eff;
      timer_d    = (!run || tick) ? '0 : timer_q + 1'b1;
      seq_d      = tick ? seq_q + 16'd1 : seq_q;
      space_ok   = (FIFO_DEPTH - int'(fifo_count)) >= PKT_BYTES;
   end

   always_comb begin
      word = 16'h0000;
      case (state_q)
         ST_HDR:  word = HEADER;
         ST_SEQ:  word = frame_seq_q;
         ST_CH:   word = {ch_q[2:0], frame_seq_q[12:0]};
`ifdef PKT_CHECKSUM_EN
         ST_CSUM: word = csum_q;
`endif
         default: word = 16'h0000;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      ch_d        = ch_q;
      frame_seq_d = frame_seq_q;
`ifdef PKT_CHECKSUM_EN
      csum_d      = csum_q;
      if (state_q != ST_IDLE && state_q != ST_CSUM && phase_q)
         csum_d = csum_q + word;
`endif
      case (state_q)
         ST_IDLE: begin
            if (tick && space_ok) begin
               state_d     = ST_HDR;
               phase_d     = 1'b0;
               frame_seq_d = seq_q;
`ifdef PKT_CHECKSUM_EN
               csum_d      = '0;
`endif
            end
         end
         default: begin
            phase_d = ~phase_q;
            if (phase_q) begin
               case (state_q)
                  ST_HDR: state_d = ST_SEQ;
                  ST_SEQ: begin
                     state_d = ST_CH;
                     ch_d    = '0;
                  end
                  ST_CH: begin
                     if (ch_q == LAST_CH)
`ifdef PKT_CHECKSUM_EN
                        state_d = ST_CSUM;
`else
                        state_d = ST_IDLE;
`endif
                     else
                        ch_d = ch_q + 8'd1;
                  end
                  default: state_d = ST_IDLE;
               endcase
            end
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         timer_q     <= '0;
         period_q    <= TW'(BASE_PERIOD);
         seq_q       <= '0;
         state_q     <= ST_IDLE;
         phase_q     <= 1'b0;
         ch_q        <= '0;
         frame_seq_q <= '0;
`ifdef PKT_CHECKSUM_EN
         csum_q      <= '0;
`endif
      end else begin
         timer_q     <= timer_d;
         period_q    <= period_d;
         seq_q       <= seq_d;
         state_q     <= state_d;
         phase_q     <= phase_d;
         ch_q        <= ch_d;
         frame_seq_q <= frame_seq_d;
`ifdef PKT_CHECKSUM_EN
         csum_q      <= csum_d;
`endif
      end
   end

   // Phase A carries the high byte, phase B the low byte.
   assign bus.db_o    = word;
   assign bus.rdreq_o = (state_q != ST_IDLE) && !phase_q;
   assign bus.wrclk_o = (state_q != ST_IDLE);
   assign wr_en       = (state_q != ST_IDLE) && !fifo_full;

   daq_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .wr_en_i   (wr_en),
      .wr_data_i (phase_q ? word[7:0] : word[15:8]),
      .rd_en_i   (bus.fifo_out_req),
      .rd_data_o (bus.fifo_out_data),
      .count_o   (fifo_count),
      .empty_o   (bus.fifo_out_empty),
      .full_o    (fifo_full)
   );
endmodule

// File: tb/tb_daq_packetizer.sv
// Scoreboard bench for daq_packetizer: expected bytes queued by stimulus, popped by a read monitor.
`timescale 1ns/1ps
module tb_daq_packetizer;
   import daq_pkg::*;

   localparam int NUM_CH = 8;
   localparam int PKT    = pkt_bytes(NUM_CH);

   logic       clk_i   = 1'b0;
   logic       reset_i = 1'b0;
   logic       en_i    = 1'b0;
   logic [2:0] os_sel_i = 3'd0;

   daq_packetizer_if bus ();

   daq_packetizer #(
      .BASE_PERIOD (200),
      .NUM_CH      (NUM_CH),
      .HEADER      (16'hA55A),
      .FIFO_DEPTH  (64)
   ) dut (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .os_sel_i (os_sel_i),
      .en_i     (en_i),
      .bus      (bus)
   );

   always #5 clk_i = ~clk_i;

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] exp_q [$];
   logic [7:0] last_exp = 8'h00;
   logic       acc_prev = 1'b0;

`ifdef PKT_CHECKSUM_EN
   logic [7:0] pkt0 [22] = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00,
                             8'h40, 8'h00, 8'h60, 8'h00, 8'h80, 8'h00, 8'hA0, 8'h00,
                             8'hC0, 8'h00, 8'hE0, 8'h00, 8'h25, 8'h5A};
`else
   logic [7:0] pkt0 [20] = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00,
                             8'h40, 8'h00, 8'h60, 8'h00, 8'h80, 8'h00, 8'hA0, 8'h00,
                             8'hC0, 8'h00, 8'hE0, 8'h00};
`endif

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic push_word(input logic [15:0] w);
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
   endtask

   task automatic push_packet(input logic [15:0] s);
      logic [15:0] sum;
      logic [15:0] w;
      sum = 16'hA55A + s;
      push_word(16'hA55A);
      push_word(s);
      for (int k = 0; k < NUM_CH; k++) begin
         w   = {k[2:0], s[12:0]};
         sum = sum + w;
         push_word(w);
      end
`ifdef PKT_CHECKSUM_EN
      push_word(sum);
`endif
   endtask

   task automatic wait_hdr(input int budget, output int cycles);
      cycles = -1;
      for (int i = 1; i <= budget; i++) begin
         @(negedge clk_i);
         if (bus.rdreq_o && bus.db_o == 16'hA55A) begin
            cycles = i;
            return;
         end
      end
   endtask

   task automatic count_strobes(input int n, output int s);
      s = 0;
      repeat (n) begin
         @(negedge clk_i);
         s += int'(bus.rdreq_o) + int'(bus.wrclk_o);
      end
   endtask

   // Read monitor: a byte is due the cycle after an accepted request.
   always @(posedge clk_i)
      acc_prev <= reset_i && bus.fifo_out_req && !bus.fifo_out_empty;

   always @(negedge clk_i) begin
      if (acc_prev) begin
         logic [7:0] e;
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_byte: got %0h, none expected", bus.fifo_out_data);
         end else begin
            e = exp_q.pop_front();
            last_exp = e;
            check("fifo_byte", bus.fifo_out_data, e);
         end
      end
   end

   initial begin
      int c;
      int w;
      bus.fifo_out_req = 1'b0;
      reset_i  = 1'b0;
      en_i     = 1'b1;
      os_sel_i = 3'd0;
      repeat (3) @(negedge clk_i);
      check("rst_db", bus.db_o, 16'h0000);
      check("rst_rdreq", bus.rdreq_o, 0);
      check("rst_wrclk", bus.wrclk_o, 0);
      check("rst_empty", bus.fifo_out_empty, 1);
      check("rst_data", bus.fifo_out_data, 8'h00);

      foreach (pkt0[i]) exp_q.push_back(pkt0[i]);
      push_packet(16'd1);
      push_packet(16'd2);
      bus.fifo_out_req = 1'b1;
      reset_i = 1'b1;
      wait_hdr(400, c);
      check("first_rdreq_latency", c, 200);
      wait_hdr(400, c);
      check("spacing_os0_a", c, 200);
      wait_hdr(400, c);
      check("spacing_os0_b", c, 200);

      // en drops a few cycles into the third frame; the frame must still finish.
      w = int'(bus.wrclk_o);
      for (int i = 0; i < 59; i++) begin
         if (i == 2) en_i = 1'b0;
         @(negedge clk_i);
         w += int'(bus.wrclk_o);
      end
      check("midframe_wr_strobes", w, PKT);
      repeat (20) @(negedge clk_i);
      check("drained_os0", exp_q.size(), 0);

      count_strobes(1000, c);
      check("en0_no_strobes", c, 0);
      en_i = 1'b1;
      os_sel_i = 3'd7;
      count_strobes(1000, c);
      check("os7_no_strobes", c, 0);

      push_packet(16'd3);
      push_packet(16'd4);
      os_sel_i = 3'd2;
      wait_hdr(1600, c);
      check("first_rdreq_os2", c, 800);
      wait_hdr(1600, c);
      check("spacing_os2", c, 800);
      en_i = 1'b0;
      repeat (60) @(negedge clk_i);
      check("drained_os2", exp_q.size(), 0);

      bus.fifo_out_req = 1'b0;
      en_i = 1'b1;
      os_sel_i = 3'd0;
      wait_hdr(400, c);
      check("seq5_frame_start", c, 200);
      repeat (5) @(negedge clk_i);
      reset_i = 1'b0;
      #1;
      check("midreset_empty", bus.fifo_out_empty, 1);
      check("midreset_wrclk", bus.wrclk_o, 0);
      check("midreset_data", bus.fifo_out_data, 8'h00);
      @(negedge clk_i);
      reset_i = 1'b1;

      // Host stays idle: the FIFO fills and later ticks are dropped, leaving a seq gap.
      repeat (1060) @(negedge clk_i);
      check("full_not_empty", bus.fifo_out_empty, 0);
      push_packet(16'd0);
      push_packet(16'd1);
`ifndef PKT_CHECKSUM_EN
      push_packet(16'd2);
`endif
      push_packet(16'd5);
      bus.fifo_out_req = 1'b1;
      repeat (260) @(negedge clk_i);
      en_i = 1'b0;
      check("drained_overflow", exp_q.size(), 0);

      repeat (5) @(negedge clk_i);
      check("empty_read_data_held", bus.fifo_out_data, last_exp);
      check("empty_read_empty", bus.fifo_out_empty, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
